// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: key FSM states, default timing and 7-segment digit codes.
package stopwatch_pkg;

    localparam int unsigned CLK_HZ              = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;   // 20 ms
    localparam int unsigned LONG_CYCLES_DEF     = CLK_HZ * 2;    // 2 s
    localparam int unsigned CNT_W_DEF           = 27;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG_HELD,
        REL_DB
    } key_state_e;

    // Segment order gfedcba, 1 = segment lit
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset value selectable.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Push-button front end: debounced level, run toggle on short press, clear pulse on long press.
// Long-press detection is built only when LONG_PRESS_EN is defined.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic RSTn3,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic clear_pulse,
    output logic run
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Counters must hold both terminal counts without wrapping
    if (64'(LONG_CYCLES) >= (64'd1 << CNT_W) || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W))
    begin : g_cnt_w_chk
        $error("stopwatch_key_ctrl: CNT_W too narrow for the timing parameters");
    end

    logic ks;

    sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
        .clk   (clk),
        .rst_n (RSTn3),
        .d_i   (key_n),
        .q_o   (ks)
    );

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             key_level_q, key_level_d;
    logic             press_q, press_d;
    logic             run_q, run_d;
`ifdef LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_flag_q, long_flag_d;
    logic             clear_q, clear_d;
`endif

    always_ff @(posedge clk or negedge RSTn3) begin
        if (!RSTn3) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            run_q       <= 1'b0;
`ifdef LONG_PRESS_EN
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            clear_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            run_q       <= run_d;
`ifdef LONG_PRESS_EN
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            clear_q     <= clear_d;
`endif
        end
    end

    // Next state; pulses default low so each lasts exactly one cycle
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        key_level_d = key_level_q;
        press_d     = 1'b0;
        run_d       = run_q;
`ifdef LONG_PRESS_EN
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        clear_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!ks) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (ks) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = HELD;
                    key_level_d = 1'b1;
                    db_cnt_d    = '0;
`ifdef LONG_PRESS_EN
                    hold_cnt_d  = '0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                // A release seen on the threshold cycle takes priority
                if (ks) begin
                    state_d     = REL_DB;
                    db_cnt_d    = '0;
`ifdef LONG_PRESS_EN
                    long_flag_d = 1'b0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    clear_d = 1'b1;
                    run_d   = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
                end
            end
`ifdef LONG_PRESS_EN
            LONG_HELD: begin
                if (ks) begin
                    state_d     = REL_DB;
                    long_flag_d = 1'b1;
                    db_cnt_d    = '0;
                end
            end
`endif
            REL_DB: begin
                if (!ks) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
`ifdef LONG_PRESS_EN
                    if (long_flag_q) begin
                        state_d = LONG_HELD;
                    end
`endif
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    key_level_d = 1'b0;
                    db_cnt_d    = '0;
`ifdef LONG_PRESS_EN
                    if (!long_flag_q) begin
                        press_d = 1'b1;
                        run_d   = ~run_q;
                    end
`else
                    press_d = 1'b1;
                    run_d   = ~run_q;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    assign key_level   = key_level_q;
    assign press_pulse = press_q;
    assign run         = run_q;
`ifdef LONG_PRESS_EN
    assign clear_pulse = clear_q;
`else
    assign clear_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Randomized self-checking bench for stopwatch_key_ctrl against a run-length reference model.
module tb_stopwatch_key_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int CW   = 5;

    logic clk;
    logic RSTn3;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic clear_pulse;
    logic run;

    stopwatch_key_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LONG),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .RSTn3       (RSTn3),
        .key_n       (key_n),
        .key_level   (key_level),
        .press_pulse (press_pulse),
        .clear_pulse (clear_pulse),
        .run         (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ks is key_n two edges late; a level change needs DB+1
    // consecutive opposite ks samples; long press counts settled-held samples.
    logic m_s1, m_s2;
    logic m_level, m_runst, m_press, m_clear, m_long;
    int   m_run_len, m_held;

    int cyc = 0;
    int n_press = 0, n_clear = 0, n_rise = 0;
    int t_press = 0, t_clear = 0, t_rise = 0, t_ref = 0;
    logic lvl_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1;  m_s2 = 1'b1;
        m_level = 1'b0; m_runst = 1'b0; m_press = 1'b0; m_clear = 1'b0; m_long = 1'b0;
        m_run_len = 0; m_held = 0;
    endtask

    task automatic model_step(input logic k);
        logic s;
        int   prev;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        m_press = 1'b0;
        m_clear = 1'b0;
        prev = m_run_len;
        m_run_len = (s == m_level) ? m_run_len + 1 : 0;
`ifdef LONG_PRESS_EN
        if (m_level && !s && prev == 0 && !m_long) begin
            m_held++;
            if (m_held == LONG) begin
                m_clear = 1'b1;
                m_runst = 1'b0;
                m_long  = 1'b1;
            end
        end
`endif
        if (m_run_len == DB + 1) begin
            m_run_len = 0;
            m_level = ~m_level;
            if (m_level) begin
                m_held = 0;
                m_long = 1'b0;
            end else if (!m_long) begin
                m_press = 1'b1;
                m_runst = ~m_runst;
            end
        end
    endtask

    // One clock with key_n = k, then compare the whole output set to the model
    task automatic cycle(input logic k);
        key_n = k;
        @(posedge clk);
        #1;
        cyc++;
        model_step(k);
        check("outputs", 32'({key_level, press_pulse, clear_pulse, run}),
              32'({m_level, m_press, m_clear, m_runst}));
        check("pulse_excl", 32'(press_pulse & clear_pulse), 32'd0);
        if (press_pulse) begin n_press++; t_press = cyc; end
        if (clear_pulse) begin n_clear++; t_clear = cyc; end
        if (key_level && !lvl_prev) begin n_rise++; t_rise = cyc; end
        lvl_prev = key_level;
    endtask

    task automatic do_reset(input logic k, input int n);
        RSTn3 = 1'b0;
        key_n = k;
        #1;
        model_reset();
        check("reset_async", 32'({key_level, press_pulse, clear_pulse, run}), 32'd0);
        repeat (n) @(posedge clk);
        #2;
        RSTn3 = 1'b1;
        lvl_prev = 1'b0;
    endtask

    task automatic short_press();
        repeat (10) cycle(1'b0);
        repeat (12) cycle(1'b1);
    endtask

    initial begin
        int p0;
        RSTn3 = 1'b0;
        key_n = 1'b1;
        #2;
        do_reset(1'b1, 3);

        // Idle after reset
        repeat (50) cycle(1'b1);
        check("idle_events", 32'(n_press + n_clear + n_rise), 32'd0);

        // Glitch shorter than the debounce window
        repeat (3) cycle(1'b0);
        repeat (12) cycle(1'b1);
        check("glitch_rise", 32'(n_rise), 32'd0);
        check("glitch_press", 32'(n_press), 32'd0);
        check("glitch_run", 32'(run), 32'd0);

        // First short press: latencies counted from the first edge sampling the change
        t_ref = cyc + 1;
        repeat (10) cycle(1'b0);
        check("rise_latency", 32'(t_rise - t_ref), 32'd6);
        t_ref = cyc + 1;
        repeat (12) cycle(1'b1);
        check("press_latency", 32'(t_press - t_ref), 32'd6);
        check("press_count1", 32'(n_press), 32'd1);
        check("run_on", 32'(run), 32'd1);

        short_press();
        check("press_count2", 32'(n_press), 32'd2);
        check("run_off", 32'(run), 32'd0);
        short_press();
        check("run_on_again", 32'(run), 32'd1);

        // Long press with run = 1
        p0 = n_press;
        t_ref = cyc + 1;
        repeat (40) cycle(1'b0);
        repeat (12) cycle(1'b1);
`ifdef LONG_PRESS_EN
        check("clear_latency", 32'(t_clear - t_ref), 32'd26);
        check("clear_count", 32'(n_clear), 32'd1);
        check("long_no_press", 32'(n_press - p0), 32'd0);
        check("long_run", 32'(run), 32'd0);
`else
        check("clear_count", 32'(n_clear), 32'd0);
        check("long_press", 32'(n_press - p0), 32'd1);
        check("long_run", 32'(run), 32'd0);
`endif

        // Release bounce: one pulse only, after the final stable high
        p0 = n_press;
        repeat (10) cycle(1'b0);
        repeat (2) cycle(1'b1);
        repeat (2) cycle(1'b0);
        t_ref = cyc + 1;
        repeat (14) cycle(1'b1);
        check("bounce_count", 32'(n_press - p0), 32'd1);
        check("bounce_latency", 32'(t_press - t_ref), 32'd6);
        check("bounce_run", 32'(run), 32'd1);

        // Reset while held at hold_cnt = 10, key released during reset
        p0 = n_press;
        repeat (17) cycle(1'b0);
        do_reset(1'b1, 3);
        repeat (30) cycle(1'b1);
        check("reset_no_press", 32'(n_press - p0), 32'd0);
        check("reset_run", 32'(run), 32'd0);

        // Random key activity with occasional resets
        for (int i = 0; i < 160; i++) begin
            logic k;
            int   len;
            k = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(22, 40))
                                              : int'($urandom_range(1, 10));
            if ($urandom_range(0, 39) == 0) begin
                do_reset(k, int'($urandom_range(1, 3)));
            end
            repeat (len) cycle(k);
        end
        repeat (20) cycle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_key_ctrl.md
Name: stopwatch_key_ctrl

Overview:
- Upstream control stage for the stopwatch counter. Takes the raw, bouncing, active-low push-button and produces clean control for the counter.
- Produces:
  - a debounced key level;
  - a run/stop level that toggles on each short press;
  - a one-cycle clear pulse on a long press.
- The counter uses run as its count enable and clear_pulse as a synchronous zero. This replaces toggling on the raw key edge.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized key must be stable to change state (20 ms at 50 MHz).
- LONG_CYCLES, 100_000_000, cycles of confirmed hold that count as a long press (2 s at 50 MHz).
- CNT_W, 27, counter width; must satisfy 2^CNT_W > LONG_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- RSTn3  in  1  reset, asynchronous, active-low.
- key_n  in  1  raw button, asynchronous, 0 = pressed.
- key_level  out  1  debounced level, 1 = pressed.
- press_pulse  out  1  one-cycle pulse on a confirmed short-press release.
- clear_pulse  out  1  one-cycle pulse when a long press is reached.
- run  out  1  stopwatch enable level.

Behaviour:
- Reset (RSTn3 = 0) forces:
  - both synchronizer flops to 1;
  - state IDLE;
  - db_cnt = 0 and hold_cnt = 0;
  - key_level = 0, press_pulse = 0, clear_pulse = 0, run = 0.
- All other logic is clocked on the rising edge of clk.
- Synchronizer: key_n passes through 2 flops to give ks; the FSM sees ks only. This adds 2 cycles of latency.
- IDLE: if ks = 0, go to PRESS_DB with db_cnt = 0.
- PRESS_DB:
  - if ks = 1, return to IDLE and clear db_cnt;
  - otherwise db_cnt increments;
  - when db_cnt = DEBOUNCE_CYCLES-1: go to HELD, key_level <= 1, hold_cnt = 0.
- HELD:
  - hold_cnt increments each cycle;
  - if ks = 1, go to REL_DB with long_flag = 0 and db_cnt = 0;
  - otherwise, when hold_cnt = LONG_CYCLES-1: go to LONG_HELD, clear_pulse = 1 for the next cycle, run <= 0 in the same cycle;
  - if release and the threshold occur in the same cycle, release wins and no long press is registered.
- LONG_HELD: if ks = 1, go to REL_DB with long_flag = 1 and db_cnt = 0.
- REL_DB:
  - if ks = 0 (bounce), return to HELD or LONG_HELD according to long_flag; hold_cnt stays frozen during REL_DB and is not cleared;
  - otherwise db_cnt increments;
  - when db_cnt = DEBOUNCE_CYCLES-1: key_level <= 0 and go to IDLE;
  - if long_flag = 0, also press_pulse = 1 for one cycle and run <= ~run in the same edge.
- Pulse rules:
  - press_pulse and clear_pulse are registered, last exactly 1 cycle and are never high together;
  - exactly one of them per press, or none if the press is rejected as a glitch.
- Counters saturate at their terminal compare and never wrap.
- A reset mid-press aborts the press with no pulse. After reset release, a key that is still held must be debounced again and is treated as a fresh press.
- A glitch shorter than DEBOUNCE_CYCLES (measured after sync) produces no output change.

Optional Feature:
- Macro: LONG_PRESS_EN.
- When defined: behaviour as above.
- When undefined:
  - LONG_HELD and hold_cnt are removed;
  - HELD goes only to REL_DB;
  - clear_pulse is tied to 0;
  - every confirmed release toggles run and pulses press_pulse, regardless of hold duration.

Decomposition:
- Package stopwatch_pkg holds:
  - the FSM state enum {IDLE, PRESS_DB, HELD, LONG_HELD, REL_DB};
  - the default timing constants (CLK_HZ = 50_000_000 and the debounce and long-press cycle counts);
  - the 7-segment digit constants shared with the display stage.
- Sub-module sync_2ff (1-bit, reset value parameterised) for the synchronizer; it is reused for other asynchronous inputs.

Test Plan (DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, LONG_PRESS_EN defined):
- Reset then idle: after RSTn3 rises with key_n = 1 for 50 cycles, all outputs stay 0.
- Glitch rejection: key_n low for 3 cycles, then high → key_level, press_pulse and run stay 0.
- Short press:
  - key_n low for 10 cycles → key_level rises 6 cycles after the falling edge (2 sync + 4 debounce);
  - on release → press_pulse = 1 for 1 cycle, 6 cycles after the rising edge;
  - run goes 0 → 1.
  - A second identical press takes run 1 → 0.
- Long press with run = 1:
  - key_n held low for 40 cycles → clear_pulse = 1 for 1 cycle at 26 cycles after the falling edge (2 + 4 + 20);
  - run = 0;
  - release gives no press_pulse.
- Release bounce:
  - during REL_DB, key_n toggles 1-0-1 with 2-cycle widths → state returns to HELD;
  - only one press_pulse, after a stable 4-cycle high.
- Reset mid-hold: RSTn3 low at hold_cnt = 10 → all outputs 0 immediately (asynchronous); no pulse after reset is released.
